cond_decode_queue: RTL and testbench

Parametrised, buffered successor to the single-cycle instruction decoder. It accepts 32-bit instructions over a valid/ready handshake and decodes the fields and enables (OP, Base, Bits, Reg_data, immediates, jump/flag/write/memory enables). It evaluates the 4-bit condition field against the current flags and stores each decoded bundle in a DEPTH-entry FIFO that feeds the execute stage. Instructions that fail their condition stay in the queue, but all their enables are cleared.

---
 rtl/cond_decode_queue.sv | 197 +++++++++++++++++++
 tb/tb_cond_decode_queue.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cond_decode_queue.sv
`default_nettype none
// ============================================================================
//  Module   : cond_decode_queue
//  Purpose  : Decodes 32-bit instructions and evaluates their ARM-style
//             condition codes against the flags sampled when each one is
//             accepted. Each decoded bundle is stored in a DEPTH-entry FIFO
//             that feeds the execute stage. An instruction that fails its
//             condition is still queued, but all of its enables are cleared.
//  Ports    : clk, rst_n (async, active-low), flush (sync queue clear)
//             in_valid/in_ready/instruction/flags  - accept side
//             out_valid/out_ready                  - head handshake
//             OP, Base, Bits, Reg_data, Iminstruction, Iminstruction_memory,
//             imm_sel, en_* / datamemory, cond_pass - head-entry fields
//             count                                - occupancy
//  Revision : 1.0  initial release
// ============================================================================
module cond_decode_queue #(
    parameter int DEPTH   = 4,
    parameter bit COND_EN = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                instruction,
    input  logic [3:0]                 flags,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 OP,
    output logic [3:0]                 Base,
    output logic [3:0]                 Bits,
    output logic [3:0]                 Reg_data,
    output logic [23:0]                Iminstruction,
    output logic [11:0]                Iminstruction_memory,
    output logic                       imm_sel,
    output logic                       en_jump,
    output logic                       en_regjump,
    output logic                       en_flags,
    output logic                       en_datawr,
    output logic                       datamemory,
    output logic                       en_datamemory,
    output logic                       cond_pass,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // instruction[27:0] holds every field output, so it is stored verbatim
    // and the fields are sliced out at the head.
    typedef struct packed {
        logic [27:0] fields;
        logic        en_jump;
        logic        en_regjump;
        logic        en_flags;
        logic        en_datawr;
        logic        datamemory;
        logic        en_datamemory;
        logic        cond_pass;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             new_entry;
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               full;
    logic               push;
    logic               pop;
    logic               cond_raw;
    logic               cond_ok;

    // ------------------------------------------------------------------
    // Condition evaluation, flags = {N,Z,C,V}
    // ------------------------------------------------------------------
    always_comb begin
        cond_raw = 1'b0;
        case (instruction[31:28])
            4'b0000: cond_raw = flags[2];
            4'b0001: cond_raw = !flags[2];
            4'b0010: cond_raw = flags[1];
            4'b0011: cond_raw = !flags[1];
            4'b0100: cond_raw = flags[3];
            4'b0101: cond_raw = !flags[3];
            4'b0110: cond_raw = flags[0];
            4'b0111: cond_raw = !flags[0];
            4'b1000: cond_raw = flags[1] && !flags[2];
            4'b1001: cond_raw = !flags[1] || flags[2];
            4'b1010: cond_raw = (flags[3] == flags[0]);
            4'b1011: cond_raw = (flags[3] != flags[0]);
            4'b1100: cond_raw = !flags[2] && (flags[3] == flags[0]);
            4'b1101: cond_raw = flags[2] || (flags[3] != flags[0]);
            4'b1110: cond_raw = 1'b1;
            default: cond_raw = 1'b0;
        endcase
    end

    generate
        if (COND_EN) begin : g_cond
            assign cond_ok = cond_raw;
        end else begin : g_no_cond
            assign cond_ok = 1'b1;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Enable decode for the incoming instruction
    // ------------------------------------------------------------------
    always_comb begin
        new_entry           = '0;
        new_entry.fields    = instruction[27:0];
        new_entry.cond_pass = cond_ok;
        case (instruction[27:26])
            2'b00: begin
                // Bits 10xx are compare/test ops: no write-back, flags always set.
                new_entry.en_datawr = (instruction[24:23] != 2'b10);
                new_entry.en_flags  = instruction[20] || (instruction[24:23] == 2'b10);
            end
            2'b01: begin
                if (instruction[20]) begin
                    new_entry.datamemory = 1'b1;
                    new_entry.en_datawr  = 1'b1;
                end else begin
                    new_entry.en_datamemory = 1'b1;
                end
            end
            2'b10:   new_entry.en_jump    = 1'b1;
            default: new_entry.en_regjump = 1'b1;
        endcase
        if (!cond_ok) begin
            new_entry.en_jump       = 1'b0;
            new_entry.en_regjump    = 1'b0;
            new_entry.en_flags      = 1'b0;
            new_entry.en_datawr     = 1'b0;
            new_entry.datamemory    = 1'b0;
            new_entry.en_datamemory = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    assign full      = (cnt == CNT_W'(DEPTH));
    assign in_ready  = !full && !flush;
    assign out_valid = (cnt != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible while counted valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= new_entry;
    end

    // ------------------------------------------------------------------
    // Head outputs, forced to zero when empty
    // ------------------------------------------------------------------
    assign head                 = out_valid ? mem[rd_ptr] : '0;
    assign OP                   = head.fields[27:26];
    assign imm_sel              = head.fields[25];
    assign Bits                 = head.fields[24:21];
    assign Base                 = head.fields[19:16];
    assign Reg_data             = head.fields[15:12];
    assign Iminstruction        = head.fields[23:0];
    assign Iminstruction_memory = head.fields[11:0];
    assign en_jump              = head.en_jump;
    assign en_regjump           = head.en_regjump;
    assign en_flags             = head.en_flags;
    assign en_datawr            = head.en_datawr;
    assign datamemory           = head.datamemory;
    assign en_datamemory        = head.en_datamemory;
    assign cond_pass            = head.cond_pass;

endmodule
`default_nettype wire

// File: tb/tb_cond_decode_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cond_decode_queue
//  Purpose  : Directed self-checking bench for cond_decode_queue (DEPTH=4)
//  Revision : 1.0  initial release
// ============================================================================
module tb_cond_decode_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instruction = '0;
    logic [3:0]  flags = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  OP;
    logic [3:0]  Base, Bits, Reg_data;
    logic [23:0] Iminstruction;
    logic [11:0] Iminstruction_memory;
    logic        imm_sel, en_jump, en_regjump, en_flags, en_datawr;
    logic        datamemory, en_datamemory, cond_pass;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cond_decode_queue #(.DEPTH(4), .COND_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .flags(flags),
        .out_valid(out_valid), .out_ready(out_ready),
        .OP(OP), .Base(Base), .Bits(Bits), .Reg_data(Reg_data),
        .Iminstruction(Iminstruction), .Iminstruction_memory(Iminstruction_memory),
        .imm_sel(imm_sel), .en_jump(en_jump), .en_regjump(en_regjump),
        .en_flags(en_flags), .en_datawr(en_datawr), .datamemory(datamemory),
        .en_datamemory(en_datamemory), .cond_pass(cond_pass), .count(count)
    );

    // Stimulus helpers: all return 1 time unit after a rising edge.
    task automatic do_push(input logic [31:0] ins, input logic [3:0] fl);
        in_valid    = 1'b1;
        instruction = ins;
        flags       = fl;
        @(posedge clk); #1;
        in_valid    = 1'b0;
    endtask

    task automatic do_pop();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (count !== 3'd0)   begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if ({OP, Bits, cond_pass, en_datawr} !== 8'd0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", {OP, Bits, cond_pass, en_datawr}); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_data();
        do_push(32'hE0812003, 4'b0000);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL data_valid got=%b exp=1", out_valid); end
        total++; if (OP !== 2'b00 || Bits !== 4'b0100 || Base !== 4'd1 || Reg_data !== 4'd2)
            begin bad++; $display("FAIL data_fields got=%b/%b/%h/%h exp=00/0100/1/2", OP, Bits, Base, Reg_data); end
        total++; if (Iminstruction_memory !== 12'h003) begin bad++; $display("FAIL data_imm12 got=%h exp=003", Iminstruction_memory); end
        total++; if ({en_datawr, en_flags, cond_pass} !== 3'b101)
            begin bad++; $display("FAIL data_enables got=%b exp=101", {en_datawr, en_flags, cond_pass}); end
        do_pop();
        total++; if (out_valid !== 1'b0 || count !== 3'd0 || en_datawr !== 1'b0 || cond_pass !== 1'b0)
            begin bad++; $display("FAIL data_empty got=%b/%0d/%b/%b exp=0/0/0/0", out_valid, count, en_datawr, cond_pass); end
    endtask

    task automatic test_cond();
        do_push(32'h03500000, 4'b0000);
        do_push(32'h03500000, 4'b0100);
        flags = 4'b0000;   // later flag changes must not affect queued entries
        total++; if (count !== 3'd2) begin bad++; $display("FAIL cond_count got=%0d exp=2", count); end
        total++; if (cond_pass !== 1'b0 || Bits !== 4'b1010 || imm_sel !== 1'b1)
            begin bad++; $display("FAIL cond_fail_fields got=%b/%b/%b exp=0/1010/1", cond_pass, Bits, imm_sel); end
        total++; if ({en_jump, en_regjump, en_flags, en_datawr, datamemory, en_datamemory} !== 6'd0)
            begin bad++; $display("FAIL cond_fail_enables got=%b exp=000000",
                {en_jump, en_regjump, en_flags, en_datawr, datamemory, en_datamemory}); end
        do_pop();
        total++; if ({cond_pass, en_flags, en_datawr} !== 3'b110)
            begin bad++; $display("FAIL cond_pass_enables got=%b exp=110", {cond_pass, en_flags, en_datawr}); end
        do_pop();
    endtask

    task automatic test_memory();
        do_push(32'hE5912004, 4'b0000);
        do_push(32'hE5812004, 4'b0000);
        total++; if ({datamemory, en_datawr, en_datamemory} !== 3'b110 || OP !== 2'b01)
            begin bad++; $display("FAIL mem_load got=%b op=%b exp=110 op=01", {datamemory, en_datawr, en_datamemory}, OP); end
        total++; if (Base !== 4'd1 || Iminstruction_memory !== 12'h004)
            begin bad++; $display("FAIL mem_load_fields got=%h/%h exp=1/004", Base, Iminstruction_memory); end
        do_pop();
        total++; if ({datamemory, en_datawr, en_datamemory} !== 3'b001)
            begin bad++; $display("FAIL mem_store got=%b exp=001", {datamemory, en_datawr, en_datamemory}); end
        total++; if (Base !== 4'd1 || Iminstruction_memory !== 12'h004)
            begin bad++; $display("FAIL mem_store_fields got=%h/%h exp=1/004", Base, Iminstruction_memory); end
        do_pop();
    endtask

    task automatic test_branch();
        do_push(32'hEA000010, 4'b0000);
        do_push(32'hEC030000, 4'b0000);
        total++; if (en_jump !== 1'b1 || en_regjump !== 1'b0 || Iminstruction !== 24'h000010)
            begin bad++; $display("FAIL branch got=%b/%b/%h exp=1/0/000010", en_jump, en_regjump, Iminstruction); end
        do_pop();
        total++; if (en_regjump !== 1'b1 || en_jump !== 1'b0 || Base !== 4'd3 || OP !== 2'b11)
            begin bad++; $display("FAIL regjump got=%b/%b/%h/%b exp=1/0/3/11", en_regjump, en_jump, Base, OP); end
        do_pop();
    endtask

    task automatic test_full();
        for (int k = 1; k <= 4; k++) do_push(32'hE0812000 + k, 4'b0000);
        total++; if (count !== 3'd4 || in_ready !== 1'b0)
            begin bad++; $display("FAIL full_state got=%0d/%b exp=4/0", count, in_ready); end
        in_valid    = 1'b1;
        instruction = 32'hE0812005;
        @(posedge clk); #1;
        total++; if (count !== 3'd4 || Iminstruction_memory !== 12'h001)
            begin bad++; $display("FAIL full_hold got=%0d/%h exp=4/001", count, Iminstruction_memory); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (count !== 3'd3 || in_ready !== 1'b1 || Iminstruction_memory !== 12'h002)
            begin bad++; $display("FAIL full_first_pop got=%0d/%b/%h exp=3/1/002", count, in_ready, Iminstruction_memory); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (count !== 3'd3 || Iminstruction_memory !== 12'h003)
            begin bad++; $display("FAIL full_push_pop got=%0d/%h exp=3/003", count, Iminstruction_memory); end
        for (int k = 4; k <= 5; k++) begin
            @(posedge clk); #1;
            total++; if (Iminstruction_memory !== 12'(k) || count !== 3'(6 - k))
                begin bad++; $display("FAIL full_order got=%h/%0d exp=%h/%0d", Iminstruction_memory, count, k, 6 - k); end
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (count !== 3'd0 || out_valid !== 1'b0)
            begin bad++; $display("FAIL full_drain got=%0d/%b exp=0/0", count, out_valid); end
    endtask

    task automatic test_flush();
        for (int k = 1; k <= 3; k++) do_push(32'hE0812010 + k, 4'b0000);
        flush       = 1'b1;
        in_valid    = 1'b1;
        instruction = 32'hEA0000FF;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        total++; if (count !== 3'd0 || out_valid !== 1'b0 || en_jump !== 1'b0)
            begin bad++; $display("FAIL flush_clear got=%0d/%b/%b exp=0/0/0", count, out_valid, en_jump); end
        do_push(32'hE0812077, 4'b0000);
        total++; if (count !== 3'd1 || Iminstruction_memory !== 12'h077)
            begin bad++; $display("FAIL flush_refill got=%0d/%h exp=1/077", count, Iminstruction_memory); end
        do_pop();
    endtask

    task automatic test_async_reset();
        for (int k = 1; k <= 3; k++) do_push(32'hE0812020 + k, 4'b0000);
        #2;
        rst_n = 1'b0;
        #1;   // mid-cycle, no clock edge yet
        total++; if (count !== 3'd0 || out_valid !== 1'b0 || en_datawr !== 1'b0 || in_ready !== 1'b1)
            begin bad++; $display("FAIL async_reset got=%0d/%b/%b/%b exp=0/0/0/1", count, out_valid, en_datawr, in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (count !== 3'd0 || out_valid !== 1'b0)
            begin bad++; $display("FAIL async_after got=%0d/%b exp=0/0", count, out_valid); end
    endtask

    initial begin
        test_reset();
        test_data();
        test_cond();
        test_memory();
        test_branch();
        test_full();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
